// File: rtl/eei_sreg_seq.sv
// eei_sreg_seq -- sequencer between the core GPR file and the snapshot
// register file (snapreg).
//
// A command names an operation (funct7), a first GPR index and a register
// count. SAVE (funct7=0x00) gathers the named GPRs into a local buffer one
// register per cycle and then offers them to the snapreg. RESTORE
// (funct7=0x40) asks the snapreg first and then scatters the returned values
// into the GPRs, one register per cycle, never writing x0. Any other funct7
// that passes the range check is forwarded to the snapreg unchanged. Every
// accepted command ends with a single-cycle done_o pulse, with error_o valid
// alongside it.
//
// Ports
//   clk_i, rst_ni                      clock, async active-low reset
//   cmd_valid_i / cmd_ready_o          command handshake (ready only in IDLE)
//   cmd_funct7_i/start_i/len_i         operation, first GPR index, count
//   gpr_raddr_o / gpr_rdata_i          combinational GPR read port
//   gpr_we_o/waddr_o/wdata_o           GPR write port
//   sreg_req_o, sreg_funct7_o,
//   sreg_batch_start_o/len_o           snapreg request and its fields
//   sreg_rs_val_o                      RS_MAX x 32 values to save, entry i at [32*i +: 32]
//   sreg_ack_i, sreg_error_i           snapreg acknowledge / error
//   sreg_rd_val_i                      RD_MAX x 32 restored values, valid with ack
//   done_o, error_o                    completion pulse, error qualified by done
module eei_sreg_seq #(
  parameter int RS_MAX = 4,
  parameter int RD_MAX = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [6:0]             cmd_funct7_i,
  input  logic [4:0]             cmd_start_i,
  input  logic [4:0]             cmd_len_i,
  output logic [4:0]             gpr_raddr_o,
  input  logic [31:0]            gpr_rdata_i,
  output logic                   gpr_we_o,
  output logic [4:0]             gpr_waddr_o,
  output logic [31:0]            gpr_wdata_o,
  output logic                   sreg_req_o,
  output logic [6:0]             sreg_funct7_o,
  output logic [4:0]             sreg_batch_start_o,
  output logic [4:0]             sreg_batch_len_o,
  output logic [32*RS_MAX-1:0]   sreg_rs_val_o,
  input  logic                   sreg_ack_i,
  input  logic                   sreg_error_i,
  input  logic [32*RD_MAX-1:0]   sreg_rd_val_i,
  output logic                   done_o,
  output logic                   error_o
);

  localparam int DATA_W = 32;
  // One buffer serves both directions, so it is sized for the larger one.
  localparam int BUF_N  = (RS_MAX > RD_MAX) ? RS_MAX : RD_MAX;

  localparam logic [6:0] F7_SAVE    = 7'h00;
  localparam logic [6:0] F7_RESTORE = 7'h40;
  localparam logic [5:0] RS_LIM     = 6'(RS_MAX);
  localparam logic [5:0] RD_LIM     = 6'(RD_MAX);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GATHER  = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_SCATTER = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state;
  // Low during reset and until the first edge after release, so that
  // cmd_ready_o is 0 while rst_ni is held low.
  logic              run;
  logic [6:0]        funct7_q;
  logic [4:0]        start_q;
  logic [4:0]        len_q;
  logic [4:0]        idx_q;
  logic              err_q;
  logic [DATA_W-1:0] sbuf [BUF_N];

  logic              accept;
  logic [5:0]        end_sum;
  logic              chk_err;
  logic [4:0]        cur_reg;
  logic              last_idx;

  assign accept   = cmd_valid_i && cmd_ready_o;
  // 6-bit sum so that start+len=32 (ending exactly at x31) is still legal.
  assign end_sum  = {1'b0, cmd_start_i} + {1'b0, cmd_len_i};
  assign cur_reg  = start_q + idx_q;
  assign last_idx = (idx_q == len_q - 5'd1);

  always_comb begin
    chk_err = (end_sum > 6'd32);
    if (cmd_funct7_i == F7_SAVE && {1'b0, cmd_len_i} > RS_LIM) begin
      chk_err = 1'b1;
    end
    if (cmd_funct7_i == F7_RESTORE && {1'b0, cmd_len_i} > RD_LIM) begin
      chk_err = 1'b1;
    end
  end

  // ---- state, command and buffer registers ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      run      <= 1'b0;
      funct7_q <= '0;
      start_q  <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < BUF_N; i++) begin
        sbuf[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            funct7_q <= cmd_funct7_i;
            start_q  <= cmd_start_i;
            len_q    <= cmd_len_i;
            idx_q    <= '0;
            err_q    <= chk_err;
            if (chk_err || cmd_len_i == 5'd0) begin
              state <= S_DONE;
            end else if (cmd_funct7_i == F7_SAVE) begin
              state <= S_GATHER;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_GATHER: begin
          for (int i = 0; i < BUF_N; i++) begin
            if (idx_q == 5'(i)) begin
              sbuf[i] <= gpr_rdata_i;
            end
          end
          if (last_idx) begin
            idx_q <= '0;
            state <= S_REQ;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        S_REQ: begin
          if (sreg_ack_i) begin
            err_q <= sreg_error_i;
            if (funct7_q == F7_RESTORE) begin
              for (int i = 0; i < RD_MAX; i++) begin
                sbuf[i] <= sreg_rd_val_i[DATA_W*i +: DATA_W];
              end
            end
            if (funct7_q == F7_RESTORE && !sreg_error_i) begin
              state <= S_SCATTER;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_SCATTER: begin
          // The x0 slot still takes its cycle; only the write enable drops.
          if (last_idx) begin
            idx_q <= '0;
            state <= S_DONE;
          end else begin
            idx_q <= idx_q + 5'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---- output decode ----
  always_comb begin
    cmd_ready_o        = run && (state == S_IDLE);
    gpr_raddr_o        = '0;
    gpr_we_o           = 1'b0;
    gpr_waddr_o        = '0;
    gpr_wdata_o        = '0;
    sreg_req_o         = 1'b0;
    sreg_funct7_o      = '0;
    sreg_batch_start_o = '0;
    sreg_batch_len_o   = '0;
    sreg_rs_val_o      = '0;
    done_o             = 1'b0;
    error_o            = 1'b0;
    case (state)
      S_GATHER: begin
        gpr_raddr_o = cur_reg;
      end
      S_REQ: begin
        sreg_req_o         = 1'b1;
        sreg_funct7_o      = funct7_q;
        sreg_batch_start_o = start_q;
        sreg_batch_len_o   = len_q;
        // Entries beyond len are zeroed so stale buffer contents never leak.
        for (int i = 0; i < RS_MAX; i++) begin
          if (5'(i) < len_q) begin
            sreg_rs_val_o[DATA_W*i +: DATA_W] = sbuf[i];
          end
        end
      end
      S_SCATTER: begin
        gpr_waddr_o = cur_reg;
        gpr_we_o    = (cur_reg != 5'd0);
        for (int i = 0; i < BUF_N; i++) begin
          if (idx_q == 5'(i)) begin
            gpr_wdata_o = sbuf[i];
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        error_o = err_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/eei_sreg_seq.md
EEI_SREG_SEQ -- requirements
Module: eei_sreg_seq

Parameters
REQ-001 The module SHALL have parameter RS_MAX, default 4, giving the maximum registers saved per command (sreg_rs_val_o entries).
REQ-002 The module SHALL have parameter RD_MAX, default 4, giving the maximum registers restored per command (sreg_rd_val_i entries).

Interface
REQ-003 clk_i  in  1  clock, all state updates on the rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid_i / cmd_ready_o  in/out  1/1  command handshake; the command transfers on a clock edge where both are 1.
REQ-006 cmd_funct7_i, cmd_start_i, cmd_len_i  in  7/5/5  operation, first GPR index, register count.
REQ-007 gpr_raddr_o / gpr_rdata_i  out/in  5/32  core GPR read port; combinational, data valid in the same cycle.
REQ-008 gpr_we_o, gpr_waddr_o, gpr_wdata_o  out  1/5/32  core GPR write port.
REQ-009 sreg_req_o, sreg_funct7_o, sreg_batch_start_o, sreg_batch_len_o  out  1/7/5/5  snapshot-regfile request.
REQ-010 sreg_rs_val_o  out  32 x RS_MAX  values to save.
REQ-011 sreg_ack_i, sreg_error_i  in  1/1  request acknowledge and error; may assert in the same cycle as sreg_req_o.
REQ-012 sreg_rd_val_i  in  32 x RD_MAX  restored values; valid while sreg_ack_i=1.
REQ-013 done_o, error_o  out  1/1  command-complete pulse; error_o is qualified by done_o.

Function
REQ-014 The FSM SHALL have states IDLE, GATHER, REQ, SCATTER and DONE; cmd_ready_o SHALL be 1 only in IDLE.
REQ-015 Command check on accept: SAVE is funct7=0x00 and RESTORE is funct7=0x40. The check SHALL set error if start+len>32 (6-bit sum), if SAVE has len>RS_MAX, or if RESTORE has len>RD_MAX.
REQ-016 On a check error, or when len=0, the FSM SHALL go IDLE->DONE with sreg_req_o never asserted. done_o SHALL equal 1 in DONE, and error_o SHALL be 1 for a check error and 0 for len=0.
REQ-017 SAVE: in GATHER, cycle i (i=0..len-1) SHALL drive gpr_raddr_o=start+i and capture gpr_rdata_i into buf[i]; the FSM SHALL enter REQ after len cycles.
REQ-018 RESTORE and any other funct7 with a passing check SHALL go IDLE->REQ directly. Unknown funct7 values SHALL be forwarded unchanged.
REQ-019 In REQ, sreg_req_o SHALL be 1 and the sreg_* fields SHALL be held at the registered command values until the cycle in which sreg_ack_i=1.
REQ-020 sreg_rs_val_o[i] SHALL be buf[i] for i<len and 0 otherwise; it SHALL be stable throughout REQ.
REQ-021 On the ack cycle, the block SHALL latch sreg_error_i. It SHALL also latch sreg_rd_val_i[0..RD_MAX-1] into buf when the funct7 is RESTORE.
REQ-022 On ack, the next state SHALL be SCATTER for a RESTORE with no sreg_error_i, and DONE otherwise; error_o SHALL be the latched sreg_error_i.
REQ-023 SCATTER: cycle i SHALL drive gpr_waddr_o=start+i and gpr_wdata_o=buf[i]; gpr_we_o SHALL be 1 except when start+i=0.
REQ-024 The x0 slot SHALL consume its cycle with no write; the FSM SHALL enter DONE after len cycles.
REQ-025 DONE SHALL last exactly one cycle with done_o=1 and SHALL then go to IDLE; a new command is accepted in the following IDLE cycle, not in DONE.
REQ-026 Outside their active states, gpr_we_o, sreg_req_o and done_o SHALL be 0; address and data outputs SHALL be 0 when idle.
REQ-027 SAVE latency: accept at edge k gives GATHER on cycles k+1..k+len, REQ from k+len+1, and done_o one cycle after the ack cycle.

Reset
REQ-028 When rst_ni=0, at any time and in any state, the block SHALL immediately set state=IDLE, clear buf and all latched command fields, and drive all outputs to 0.
REQ-029 cmd_ready_o SHALL be 1 from the first clock edge after reset is released; an aborted command SHALL produce no write and no done_o pulse.

Verification
REQ-030 SAVE with start=5, len=3 and GPR x5..x7=0xA,0xB,0xC, ack on the first REQ cycle: the bench SHALL see reads 5,6,7, then sreg_rs_val_o={0xA,0xB,0xC,0}, then done_o=1 and error_o=0 exactly 5 cycles after accept.
REQ-031 RESTORE with start=0, len=3, rd_val={1,2,3}, and ack delayed by 4 cycles: the bench SHALL see sreg_req_o held for 5 cycles, no write to x0, then writes x1=2 and x2=3, then done_o=1.
REQ-032 SAVE with len=5 (>RS_MAX) and start=30, len=3: for each, the bench SHALL see no sreg_req_o, and done_o=1 with error_o=1 one cycle after accept.
REQ-033 funct7=0x7F with len=1 and the snapreg returning sreg_error_i=1 on ack: the bench SHALL see one request, no GPR write, and done_o=1 with error_o=1.
REQ-034 rst_ni pulsed low mid-SCATTER: the bench SHALL see gpr_we_o=0 immediately, no done_o pulse, cmd_ready_o=1 after release, and a following SAVE completing normally.
